// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for serial_mag_comparator: operands and mode in, handshake and
// ordering flags out.
interface serial_mag_comparator_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             diff;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, diff, eq, lt, gt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, diff, eq, lt, gt
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the captured operands MSB chunk first, STEP bits
// per clock, and stops on the first differing chunk with a registered eq/lt/gt/diff result.
module serial_mag_comparator #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus_io
);

  localparam int unsigned NSTEPS = WIDTH / STEP;
  localparam int unsigned CntW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, diff_q, eq_q, lt_q, gt_q;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [STEP-1:0]  chunk_a, chunk_b;
  logic             chunk_lt, chunk_gt, last_chunk;

  always_comb begin
    a_sh    = a_q << (32'(cnt_q) * STEP);
    b_sh    = b_q << (32'(cnt_q) * STEP);
    chunk_a = a_sh[WIDTH-1 -: STEP];
    chunk_b = b_sh[WIDTH-1 -: STEP];
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (sgn_q && (cnt_q == '0)) begin
      chunk_a[STEP-1] = ~chunk_a[STEP-1];
      chunk_b[STEP-1] = ~chunk_b[STEP-1];
    end
    chunk_lt   = chunk_a < chunk_b;
    chunk_gt   = chunk_a > chunk_b;
    last_chunk = (cnt_q == CntW'(NSTEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus_io.start) begin
            a_q     <= bus_io.a;
            b_q     <= bus_io.b;
            sgn_q   <= bus_io.signed_mode;
            cnt_q   <= '0;
            diff_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (chunk_lt || chunk_gt) begin
            diff_q  <= 1'b1;
            lt_q    <= chunk_lt;
            gt_q    <= chunk_gt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (last_chunk) begin
            eq_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.diff = diff_q;
  assign bus_io.eq   = eq_q;
  assign bus_io.lt   = lt_q;
  assign bus_io.gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and randomized bench for serial_mag_comparator with STEP=1 and STEP=2 instances,
// checked against an arithmetic reference model.
module tb_serial_mag_comparator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_mag_comparator_if #(.WIDTH(6)) if1 ();
  serial_mag_comparator_if #(.WIDTH(6)) if2 ();

  serial_mag_comparator #(.WIDTH(6), .STEP(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if1)
  );

  serial_mag_comparator #(.WIDTH(6), .STEP(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic st, input logic sm,
                       input logic [5:0] a, input logic [5:0] b);
    if (which == 1) begin
      if1.start = st; if1.signed_mode = sm; if1.a = a; if1.b = b;
    end else begin
      if2.start = st; if2.signed_mode = sm; if2.a = a; if2.b = b;
    end
  endtask

  // Packed as {busy, done, diff, eq, lt, gt}.
  task automatic sample(input int which, output logic [5:0] v);
    if (which == 1) v = {if1.busy, if1.done, if1.diff, if1.eq, if1.lt, if1.gt};
    else            v = {if2.busy, if2.done, if2.diff, if2.eq, if2.lt, if2.gt};
  endtask

  // Reference ordering from plain integer comparison: {eq, lt, gt}.
  function automatic logic [2:0] ref_res(input logic sm, input logic [5:0] a,
                                         input logic [5:0] b);
    int ia, ib;
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    return {ia == ib, ia < ib, ia > ib};
  endfunction

  // Latency = chunk holding the highest differing bit, plus one.
  function automatic int ref_k(input logic [5:0] a, input logic [5:0] b, input int step);
    logic [5:0] x;
    x = a ^ b;
    if (x == 6'd0) return 6 / step;
    for (int p = 5; p >= 0; p--) if (x[p]) return (5 - p) / step + 1;
    return 0;
  endfunction

  task automatic start_cmp(input int which, input logic sm, input logic [5:0] a,
                           input logic [5:0] b);
    logic [5:0] v;
    drive(which, 1'b1, sm, a, b);
    @(posedge clk); #1;
    sample(which, v);
    chk("accept_busy", v, 6'b100000);
    drive(which, 1'b0, 1'($urandom), 6'($urandom), 6'($urandom));
  endtask

  task automatic wait_done(input int which, output int k, output logic [5:0] v);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      sample(which, v);
    end while (!v[4] && k < 20);
    chk("done_seen", v[4], 1);
  endtask

  task automatic run(input int which, input logic sm, input logic [5:0] a,
                     input logic [5:0] b, output int k, output logic [5:0] v);
    logic [2:0] r;
    start_cmp(which, sm, a, b);
    wait_done(which, k, v);
    r = ref_res(sm, a, b);
    chk("latency", k, ref_k(a, b, which));
    chk("result", v, {1'b0, 1'b1, r[1] | r[0], r});
  endtask

  initial begin
    int         k;
    int         k2;
    logic [5:0] v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1, 1'b0, 1'b0, 6'd0, 6'd0);
    drive(2, 1'b0, 1'b0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    sample(1, v); chk("reset_dut1", v, 6'b000000);
    sample(2, v); chk("reset_dut2", v, 6'b000000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned, first difference at bit 3.
    run(1, 1'b0, 6'b001010, 6'b000101, k, v);
    chk("t1_k", k, 3);
    chk("t1_res", v, 6'b011001);
    @(posedge clk); #1;

    // Equal operands, then hold across idle cycles.
    run(1, 1'b0, 6'b000010, 6'b000010, k, v);
    chk("t2_k", k, 6);
    chk("t2_res", v, 6'b010100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample(1, v);
      chk("t2_hold", v, 6'b000100);
    end

    // Signed vs unsigned ordering of the same bit patterns.
    run(1, 1'b1, 6'b100000, 6'b000001, k, v);
    chk("t3_signed_k", k, 1);
    chk("t3_signed", v, 6'b011010);
    run(1, 1'b0, 6'b100000, 6'b000001, k, v);
    chk("t3_unsigned_k", k, 1);
    chk("t3_unsigned", v, 6'b011001);
    run(1, 1'b1, 6'b111111, 6'b111110, k, v);
    chk("t3_neg_k", k, 6);
    chk("t3_neg", v, 6'b011001);

    // Two bits per cycle.
    run(2, 1'b0, 6'b010000, 6'b000001, k, v);
    chk("t4_gt_k", k, 1);
    chk("t4_gt", v, 6'b011001);
    run(2, 1'b0, 6'b000100, 6'b000101, k, v);
    chk("t4_lt_k", k, 3);
    chk("t4_lt", v, 6'b011010);
    @(posedge clk); #1;

    // Start pulsed mid-RUN with new operands must be ignored.
    start_cmp(1, 1'b0, 6'b000010, 6'b000010);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 6'b111111, 6'b000000);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 6'b000000, 6'b111111);
    sample(1, v);
    chk("mid_start_busy", v, 6'b100000);
    wait_done(1, k, v);
    chk("mid_start_k", k + 2, 6);
    chk("mid_start_res", v, 6'b010100);

    // Back-to-back: start during the done cycle (run re-arms immediately).
    run(1, 1'b0, 6'b110000, 6'b100000, k, v);
    chk("b2b_first_k", k, 2);
    run(1, 1'b0, 6'b000001, 6'b000000, k, v);
    chk("b2b_second_k", k, 6);
    chk("b2b_second", v, 6'b011001);
    @(posedge clk); #1;

    // Reset two cycles into a six-cycle compare.
    start_cmp(1, 1'b0, 6'b000010, 6'b000010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sample(1, v);
    chk("rst_mid_now", v, 6'b000000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sample(1, v);
      chk("rst_no_done", v, 6'b000000);
    end
    run(1, 1'b0, 6'b101010, 6'b101011, k, v);
    chk("rst_fresh_k", k, 6);
    chk("rst_fresh", v, 6'b011010);

    // Random traffic on both instances, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 60; i++) begin
      int         w;
      logic [5:0] ra, rb;
      w  = (($urandom & 1) != 0) ? 1 : 2;
      ra = 6'($urandom);
      rb = (($urandom_range(0, 3)) == 0) ? ra : 6'($urandom);
      run(w, 1'($urandom), ra, rb, k2, v);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
